// File: rtl/pipeline_hazard_ctrl.sv
// Purpose : freeze/flush control for every pipeline register (load-use/RAW, branch, SRAM wait).
// Latency : outputs combinational from state and inputs; counters update on the next rising edge.
// Backpr. : mem_busy holds PC..EX/MEM and bubbles MEM/WB; branch flush is deferred while busy.
//
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-low reset
//   src1, src2, two_src      ID source registers; two_src marks src2 as read
//   fwd_en                   forwarding unit present, only load-use then stalls
//   EXE_Dest/WB_EN/MEM_R_EN  ID/EX register outputs; EXE_B = branch taken in EXE
//   MEM_Dest/WB_EN/R_EN/W_EN EX/MEM register outputs
//   pc_freeze .. mem_busy    per-stage hold/bubble controls
//   stall_count, flush_count saturating performance counters
module pipeline_hazard_ctrl #(
   parameter int SRAM_WAIT = 4,
   parameter int CNT_W     = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       src1,
   input  logic [3:0]       src2,
   input  logic             two_src,
   input  logic             fwd_en,
   input  logic [3:0]       EXE_Dest,
   input  logic             EXE_WB_EN,
   input  logic             EXE_MEM_R_EN,
   input  logic             EXE_B,
   input  logic [3:0]       MEM_Dest,
   input  logic             MEM_WB_EN,
   input  logic             MEM_R_EN,
   input  logic             MEM_W_EN,
   output logic             pc_freeze,
   output logic             if_id_freeze,
   output logic             if_id_flush,
   output logic             id_ex_freeze,
   output logic             id_ex_flush,
   output logic             ex_mem_freeze,
   output logic             mem_wb_flush,
   output logic             mem_busy,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count
);

   // The IDLE cycle itself is the first busy cycle, so WAIT only needs SRAM_WAIT-2 extra counts.
   localparam int CW = (SRAM_WAIT > 2) ? $clog2(SRAM_WAIT) : 1;
   localparam logic [CW-1:0] CNT_LOAD = CW'((SRAM_WAIT >= 2) ? (SRAM_WAIT - 2) : 0);

   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic          busy;
   logic          mem_req;
   logic          hazard;
   logic          stall_inc;
   logic          flush_inc;

   assign mem_req = MEM_R_EN | MEM_W_EN;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // DONE always returns to IDLE so the instruction that just finished its access
   // cannot re-trigger the wait; a back-to-back access is picked up in IDLE.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      busy      = 1'b0;
      case (state)
         IDLE: begin
            if (mem_req && (SRAM_WAIT >= 1)) begin
               busy = 1'b1;
               if (SRAM_WAIT == 1) begin
                  state_nxt = DONE;
               end else begin
                  state_nxt = WAIT;
                  cnt_nxt   = CNT_LOAD;
               end
            end
         end
         WAIT: begin
            busy = 1'b1;
            if (cnt == '0) state_nxt = DONE;
            else           cnt_nxt   = cnt - 1'b1;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // With forwarding only a load in EXE cannot be bypassed in time; without it any
   // pending writer in EXE or MEM blocks the read.
   always_comb begin
      hazard = 1'b0;
      if (fwd_en) begin
         hazard = EXE_MEM_R_EN & ((src1 == EXE_Dest) | (two_src & (src2 == EXE_Dest)));
      end else begin
         hazard = ((src1 == EXE_Dest) & EXE_WB_EN) | ((src1 == MEM_Dest) & MEM_WB_EN) |
                  (two_src & (((src2 == EXE_Dest) & EXE_WB_EN) | ((src2 == MEM_Dest) & MEM_WB_EN)));
      end
   end

   // Priority busy > branch > hazard. A branch seen while busy is not lost: ID/EX and
   // EX/MEM are frozen, so EXE_B is still presented once busy drops.
   always_comb begin
      pc_freeze     = 1'b0;
      if_id_freeze  = 1'b0;
      if_id_flush   = 1'b0;
      id_ex_freeze  = 1'b0;
      id_ex_flush   = 1'b0;
      ex_mem_freeze = 1'b0;
      mem_wb_flush  = 1'b0;
      mem_busy      = 1'b0;
      stall_inc     = 1'b0;
      flush_inc     = 1'b0;
      if (rst) begin
         if (busy) begin
            mem_busy      = 1'b1;
            pc_freeze     = 1'b1;
            if_id_freeze  = 1'b1;
            id_ex_freeze  = 1'b1;
            ex_mem_freeze = 1'b1;
            mem_wb_flush  = 1'b1;
         end else if (EXE_B) begin
            if_id_flush   = 1'b1;
            id_ex_flush   = 1'b1;
            flush_inc     = 1'b1;
         end else if (hazard) begin
            pc_freeze     = 1'b1;
            if_id_freeze  = 1'b1;
            id_ex_flush   = 1'b1;
            stall_inc     = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_count <= '0;
         flush_count <= '0;
      end else begin
         if (stall_inc && (stall_count != '1)) stall_count <= stall_count + 1'b1;
         if (flush_inc && (flush_count != '1)) flush_count <= flush_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Purpose : bench for pipeline_hazard_ctrl with SRAM_WAIT 4/1/0 and a narrow-counter copy.
// Latency : reference model evaluated every falling edge against all four instances.
// Backpr. : none; the clock free-runs and every wait is a clock edge.
module tb_pipeline_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] src1, src2, EXE_Dest, MEM_Dest;
   logic       two_src, fwd_en, EXE_WB_EN, EXE_MEM_R_EN, EXE_B, MEM_WB_EN, MEM_R_EN, MEM_W_EN;

   // {pc_freeze, if_id_freeze, if_id_flush, id_ex_freeze, id_ex_flush, ex_mem_freeze, mem_wb_flush, mem_busy}
   logic [7:0]  dout   [4];
   logic [31:0] dstall [4];
   logic [31:0] dflush [4];

   int          WV [4] = '{4, 1, 0, 4};
   logic [31:0] MX [4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd3};

   localparam logic [7:0] V_BUSY  = 8'b1101_0111;
   localparam logic [7:0] V_FLUSH = 8'b0010_1000;
   localparam logic [7:0] V_STALL = 8'b1100_1000;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 4; g++) begin : gd
      localparam int W  = (g == 0) ? 4 : (g == 1) ? 1 : (g == 2) ? 0 : 4;
      localparam int CW = (g == 3) ? 2 : 32;
      logic [7:0]    o;
      logic [CW-1:0] sc, fc;
      pipeline_hazard_ctrl #(.SRAM_WAIT(W), .CNT_W(CW)) u_dut (
         .clk(clk), .rst(rst), .src1(src1), .src2(src2), .two_src(two_src), .fwd_en(fwd_en),
         .EXE_Dest(EXE_Dest), .EXE_WB_EN(EXE_WB_EN), .EXE_MEM_R_EN(EXE_MEM_R_EN), .EXE_B(EXE_B),
         .MEM_Dest(MEM_Dest), .MEM_WB_EN(MEM_WB_EN), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN),
         .pc_freeze(o[7]), .if_id_freeze(o[6]), .if_id_flush(o[5]), .id_ex_freeze(o[4]),
         .id_ex_flush(o[3]), .ex_mem_freeze(o[2]), .mem_wb_flush(o[1]), .mem_busy(o[0]),
         .stall_count(sc), .flush_count(fc));
      assign dout[g]   = o;
      assign dstall[g] = 32'(sc);
      assign dflush[g] = 32'(fc);
   end

   // ---------------- reference model ----------------
   // Each access occupies MEM for W+1 cycles: W busy cycles then one release cycle.
   bit          m_act [4] = '{0, 0, 0, 0};
   int          m_ph  [4] = '{0, 0, 0, 0};
   logic [31:0] m_st  [4] = '{0, 0, 0, 0};
   logic [31:0] m_fl  [4] = '{0, 0, 0, 0};

   function automatic bit reads(input logic [3:0] r);
      return (src1 == r) || (two_src && (src2 == r));
   endfunction

   function automatic bit haz_m();
      if (fwd_en) return EXE_MEM_R_EN && reads(EXE_Dest);
      return (EXE_WB_EN && reads(EXE_Dest)) || (MEM_WB_EN && reads(MEM_Dest));
   endfunction

   function automatic logic [7:0] exp_vec(input bit r, input bit b, input bit br, input bit h);
      if (!r)  return 8'h00;
      if (b)   return V_BUSY;
      if (br)  return V_FLUSH;
      if (h)   return V_STALL;
      return 8'h00;
   endfunction

   always @(negedge clk) begin
      bit         b, h;
      logic [7:0] e;
      h = haz_m();
      for (int k = 0; k < 4; k++) begin
         if (!rst) begin
            m_act[k] = 0; m_ph[k] = 0; m_st[k] = 0; m_fl[k] = 0;
         end
         b = rst && (m_act[k] ? (m_ph[k] < WV[k]) : ((MEM_R_EN || MEM_W_EN) && (WV[k] >= 1)));
         e = exp_vec(rst, b, EXE_B, h);
         n_cmp++;
         if (dout[k] !== e) begin
            n_bad++;
            $display("FAIL model_out inst%0d t=%0t: got %b want %b", k, $time, dout[k], e);
         end
         n_cmp++;
         if (dstall[k] !== m_st[k]) begin
            n_bad++;
            $display("FAIL model_stall inst%0d t=%0t: got %0d want %0d", k, $time, dstall[k], m_st[k]);
         end
         n_cmp++;
         if (dflush[k] !== m_fl[k]) begin
            n_bad++;
            $display("FAIL model_flush inst%0d t=%0t: got %0d want %0d", k, $time, dflush[k], m_fl[k]);
         end
         if (rst) begin
            if (!b && EXE_B && m_fl[k] < MX[k]) m_fl[k]++;
            if (!b && !EXE_B && h && m_st[k] < MX[k]) m_st[k]++;
            if (!m_act[k]) begin
               if ((MEM_R_EN || MEM_W_EN) && WV[k] >= 1) begin
                  m_act[k] = 1;
                  m_ph[k]  = 1;
               end
            end else begin
               m_ph[k]++;
               if (m_ph[k] > WV[k]) m_act[k] = 0;
            end
         end
      end
   end

   // ---------------- directed + random stimulus ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic clear();
      src1 = 0; src2 = 0; two_src = 0; fwd_en = 0; EXE_Dest = 0; EXE_WB_EN = 0;
      EXE_MEM_R_EN = 0; EXE_B = 0; MEM_Dest = 0; MEM_WB_EN = 0; MEM_R_EN = 0; MEM_W_EN = 0;
   endtask

   task automatic load_use();
      fwd_en = 1; EXE_MEM_R_EN = 1; EXE_Dest = 4'd3; src1 = 4'd3;
   endtask

   task automatic go();
      @(posedge clk); #1;
   endtask

   task automatic samp();
      @(negedge clk); #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [9:0]  p0, p1, p2;
      logic [4:0]  pr;
      logic [31:0] s0, f0;

      // reset: outputs forced low even with active inputs
      rst = 0; clear();
      samp();
      chk("rst_out", 32'(dout[0]), 0);
      chk("rst_stall", dstall[0], 0);
      chk("rst_flush", dflush[0], 0);
      MEM_R_EN = 1; EXE_B = 1;
      samp();
      chk("rst_gated", 32'(dout[0]), 0);
      go(); rst = 1; clear(); samp();
      chk("idle_out", 32'(dout[0]), 0);

      // load-use with forwarding
      go(); clear(); load_use(); samp();
      chk("loaduse_out", 32'(dout[0]), 32'(V_STALL));
      go(); clear(); samp();
      chk("loaduse_cnt", dstall[0], 1);
      chk("loaduse_gone", 32'(dout[0]), 0);
      go(); clear(); load_use(); EXE_MEM_R_EN = 0; samp();
      chk("noload_out", 32'(dout[0]), 0);

      // no forwarding, src2 RAW on MEM
      go(); clear(); MEM_WB_EN = 1; MEM_Dest = 4'd5; two_src = 1; src2 = 4'd5; samp();
      chk("raw_src2_out", 32'(dout[0]), 32'(V_STALL));
      go(); clear(); MEM_WB_EN = 1; MEM_Dest = 4'd5; two_src = 0; src2 = 4'd5; samp();
      chk("raw_one_src_out", 32'(dout[0]), 0);

      // branch
      go(); clear(); EXE_B = 1; samp();
      chk("branch_out", 32'(dout[0]), 32'(V_FLUSH));
      go(); clear(); samp();
      chk("branch_cnt", dflush[0], 1);

      // SRAM busy patterns with MEM_R_EN held for 10 cycles
      for (int i = 0; i < 10; i++) begin
         go(); clear(); MEM_R_EN = 1; samp();
         p0[9-i] = dout[0][0]; p1[9-i] = dout[1][0]; p2[9-i] = dout[2][0];
         if (i == 0) chk("busy_vec", 32'(dout[0]), 32'(V_BUSY));
      end
      chk("busy_w4", 32'(p0), 32'(10'b1111011110));
      chk("busy_w1", 32'(p1), 32'(10'b1010101010));
      chk("busy_w0", 32'(p2), 0);

      // branch during busy is deferred to the release cycle
      for (int i = 0; i < 5; i++) begin
         go(); clear(); MEM_R_EN = 1; EXE_B = 1; samp();
         if (i == 0) f0 = dflush[0];
         chk($sformatf("br_busy_%0d", i), 32'(dout[0]), (i < 4) ? 32'(V_BUSY) : 32'(V_FLUSH));
      end
      go(); clear(); samp();
      chk("br_busy_cnt", dflush[0], f0 + 1);

      // branch and hazard together: only the flush
      go(); clear(); load_use(); EXE_B = 1; samp();
      s0 = dstall[0]; f0 = dflush[0];
      chk("br_haz_out", 32'(dout[0]), 32'(V_FLUSH));
      go(); clear(); samp();
      chk("br_haz_stall", dstall[0], s0);
      chk("br_haz_flush", dflush[0], f0 + 1);

      // reset in the middle of WAIT
      go(); clear(); MEM_R_EN = 1; samp();
      go(); samp();
      go(); rst = 0; samp();
      chk("midrst_out", 32'(dout[0]), 0);
      chk("midrst_stall", dstall[0], 0);
      chk("midrst_flush", dflush[0], 0);
      go(); rst = 1; clear(); samp();
      chk("postrst_idle", 32'(dout[0]), 0);
      for (int i = 0; i < 5; i++) begin
         go(); clear(); MEM_R_EN = 1; samp();
         pr[4-i] = dout[0][0];
      end
      chk("postrst_busy", 32'(pr), 32'(5'b11110));

      // saturation of the 2-bit counter copy
      for (int i = 0; i < 5; i++) begin
         go(); clear(); load_use(); samp();
      end
      go(); clear(); samp();
      chk("sat_wide", dstall[0], 5);
      chk("sat_narrow", dstall[3], 3);

      // random traffic, narrow register range to provoke matches
      for (int i = 0; i < 4000; i++) begin
         go();
         rst          = ($urandom_range(0, 299) != 0);
         src1         = 4'($urandom_range(0, 5));
         src2         = 4'($urandom_range(0, 5));
         EXE_Dest     = 4'($urandom_range(0, 5));
         MEM_Dest     = 4'($urandom_range(0, 5));
         two_src      = 1'($urandom_range(0, 1));
         fwd_en       = 1'($urandom_range(0, 1));
         EXE_WB_EN    = 1'($urandom_range(0, 1));
         EXE_MEM_R_EN = 1'($urandom_range(0, 1));
         MEM_WB_EN    = 1'($urandom_range(0, 1));
         EXE_B        = ($urandom_range(0, 5) == 0);
         MEM_R_EN     = ($urandom_range(0, 4) == 0);
         MEM_W_EN     = ($urandom_range(0, 6) == 0);
         samp();
      end

      go(); rst = 1; clear(); samp();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
